// File: rtl/alu_issue.sv
// RV32 ALU issue stage: decodes one instruction into ALU op/operands and
// holds it in a single registered output entry with valid/ready flow control.
module alu_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        illegal,
  output logic [7:0]  illegal_count
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;

  logic [6:0]  w_opcode;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_u;
  logic [2:0]  w_op;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic        w_illegal;
  logic        w_accept;

  logic        r_out_valid;
  logic [2:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_illegal;
  logic [7:0]  r_count;

  assign w_opcode = instr[6:0];
  assign w_f3     = instr[14:12];
  assign w_f7     = instr[31:25];
  assign w_imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign w_imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign w_imm_u  = {instr[31:12], 12'b0};

  always_comb begin
    w_op      = OP_ADD;
    w_a       = rs1_data;
    w_b       = 32'b0;
    w_illegal = 1'b0;
    case (w_opcode)
      OPC_OP: begin
        w_b = rs2_data;
        if (w_f7 == 7'b0000000) begin
          case (w_f3)
            3'b000:  w_op = OP_ADD;
            3'b111:  w_op = OP_AND;
            3'b110:  w_op = OP_OR;
            3'b100:  w_op = OP_XOR;
            default: w_illegal = 1'b1;
          endcase
        end else if (w_f7 == 7'b0100000 && w_f3 == 3'b000) begin
          w_op = OP_SUB;
        end else begin
          w_illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        w_b = w_imm_i;
        case (w_f3)
          3'b000:  w_op = OP_ADD;
          3'b111:  w_op = OP_AND;
          3'b110:  w_op = OP_OR;
          3'b100:  w_op = OP_XOR;
          default: w_illegal = 1'b1;
        endcase
      end
      OPC_LOAD:  w_b = w_imm_i;
      OPC_STORE: w_b = w_imm_s;
      OPC_BRANCH: begin
        w_op = OP_SUB;
        w_b  = rs2_data;
        if (w_f3 != 3'b000 && w_f3 != 3'b001) w_illegal = 1'b1;
      end
      OPC_LUI: begin
        w_a = 32'b0;
        w_b = w_imm_u;
      end
      OPC_AUIPC: begin
        w_a = pc;
        w_b = w_imm_u;
      end
      default: w_illegal = 1'b1;
    endcase
    // Unsupported encodings present a clean zeroed payload downstream.
    if (w_illegal) begin
      w_op = OP_ADD;
      w_a  = 32'b0;
      w_b  = 32'b0;
    end
  end

  // Handshake: a transfer happens on an edge where valid && ready are both 1.
  // Upstream: in_ready does not depend on in_valid; flush blocks input.
  // Downstream: the entry is held unchanged until out_valid && out_ready.
  assign in_ready = !flush && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_op        <= OP_ADD;
      r_a         <= 32'b0;
      r_b         <= 32'b0;
      r_illegal   <= 1'b0;
      r_count     <= 8'd0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_op        <= w_op;
      r_a         <= w_a;
      r_b         <= w_b;
      r_illegal   <= w_illegal;
      if (w_illegal && r_count != 8'hFF) r_count <= r_count + 8'd1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid     = r_out_valid;
  assign alu_op        = r_op;
  assign alu_a         = r_a;
  assign alu_b         = r_b;
  assign illegal       = r_illegal;
  assign illegal_count = r_count;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed scenarios plus randomized traffic, checked each
// cycle against a transaction-level reference model and an expected-entry queue.
module tb_alu_issue;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        illegal;
  logic [7:0]  illegal_count;

  int n_tests = 0;
  int n_fail  = 0;
  int n_xfer  = 0;

  // Entry layout: {illegal, op[2:0], a[31:0], b[31:0]}
  logic [67:0] exp_q[$];
  logic [67:0] m_pay;
  int          m_cnt;
  bit          m_known = 0;

  alu_issue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .illegal(illegal),
    .illegal_count(illegal_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference decode written straight from the instruction-set table.
  function automatic logic [67:0] ref_decode(input logic [31:0] ins, input logic [31:0] p,
                                             input logic [31:0] r1, input logic [31:0] r2);
    int unsigned opc = ins[6:0];
    int unsigned f3  = ins[14:12];
    int unsigned f7  = ins[31:25];
    int          imm_i = int'($signed(ins[31:20]));
    int          imm_s = int'($signed({ins[31:25], ins[11:7]}));
    logic [31:0] imm_u = ins[31:12] * 32'd4096;
    if (opc == 'h33 && f7 == 0 && f3 == 0)    return {1'b0, 3'd0, r1, r2};
    if (opc == 'h33 && f7 == 'h20 && f3 == 0) return {1'b0, 3'd1, r1, r2};
    if (opc == 'h33 && f7 == 0 && f3 == 7)    return {1'b0, 3'd2, r1, r2};
    if (opc == 'h33 && f7 == 0 && f3 == 6)    return {1'b0, 3'd3, r1, r2};
    if (opc == 'h33 && f7 == 0 && f3 == 4)    return {1'b0, 3'd4, r1, r2};
    if (opc == 'h13 && f3 == 0) return {1'b0, 3'd0, r1, 32'(imm_i)};
    if (opc == 'h13 && f3 == 7) return {1'b0, 3'd2, r1, 32'(imm_i)};
    if (opc == 'h13 && f3 == 6) return {1'b0, 3'd3, r1, 32'(imm_i)};
    if (opc == 'h13 && f3 == 4) return {1'b0, 3'd4, r1, 32'(imm_i)};
    if (opc == 'h03) return {1'b0, 3'd0, r1, 32'(imm_i)};
    if (opc == 'h23) return {1'b0, 3'd0, r1, 32'(imm_s)};
    if (opc == 'h63 && f3 <= 1) return {1'b0, 3'd1, r1, r2};
    if (opc == 'h37) return {1'b0, 3'd0, 32'd0, imm_u};
    if (opc == 'h17) return {1'b0, 3'd0, p, imm_u};
    return {1'b1, 3'd0, 32'd0, 32'd0};
  endfunction

  // scoreboard: check observed outputs, then advance the model for the next edge
  always @(negedge clk) begin
    logic        acc;
    logic [67:0] e;
    logic [67:0] head;
    if (m_known) begin
      check("in_ready", 68'(in_ready), 68'(!flush && (exp_q.size() == 0 || out_ready)));
      check("out_valid", 68'(out_valid), 68'(exp_q.size() != 0));
      check("payload", {illegal, alu_op, alu_a, alu_b}, m_pay);
      check("illegal_count", 68'(illegal_count), 68'(m_cnt));
    end
    if (rst) begin
      exp_q.delete();
      m_pay   = '0;
      m_cnt   = 0;
      m_known = 1;
    end else if (m_known) begin
      if (flush) begin
        exp_q.delete();
      end else begin
        acc = in_valid && (exp_q.size() == 0 || out_ready);
        if (exp_q.size() != 0 && out_ready) begin
          head = exp_q.pop_front();
          check("xfer_entry", {illegal, alu_op, alu_a, alu_b}, head);
          n_xfer++;
        end
        if (acc) begin
          e = ref_decode(instr, pc, rs1_data, rs2_data);
          exp_q.push_back(e);
          m_pay = e;
          if (e[67] && m_cnt < 255) m_cnt++;
        end
      end
    end
  end

  // driver: apply one cycle of inputs, return just after the capturing edge
  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] p,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic ordy, input logic fl, input logic rs);
    in_valid  = v;
    instr     = ins;
    pc        = p;
    rs1_data  = a;
    rs2_data  = b;
    out_ready = ordy;
    flush     = fl;
    rst       = rs;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] opcs [8];
    logic [31:0] w;
    int k;
    opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h00};
    w = $urandom();
    k = $urandom_range(0, 8);
    w[6:0] = (k < 8) ? opcs[k] : 7'($urandom());
    case ($urandom_range(0, 2))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    int x0;
    in_valid = 0; instr = 0; pc = 0; rs1_data = 0; rs2_data = 0;
    out_ready = 0; flush = 0; rst = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    check("rst_valid", 68'(out_valid), 68'(0));
    check("rst_cnt", 68'(illegal_count), 68'(0));
    rst = 0; in_valid = 1; instr = 32'h002081B3; rs1_data = 5; rs2_data = 7; out_ready = 1;
    #1 check("ready_after_rst", 68'(in_ready), 68'(1));

    // add x3,x1,x2
    drive(1, 32'h002081B3, 0, 5, 7, 1, 0, 0);
    check("add_valid", 68'(out_valid), 68'(1));
    check("add_entry", {illegal, alu_op, alu_a, alu_b}, {1'b0, 3'd0, 32'd5, 32'd7});

    // sub held for three stalled cycles
    drive(1, 32'h402081B3, 4, 9, 3, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h002081B3, 8, 1, 1, 0, 0, 0);
      check("stall_ready", 68'(in_ready), 68'(0));
      check("stall_entry", {out_valid, illegal, alu_op, alu_a, alu_b}, {2'b10, 3'd1, 32'd9, 32'd3});
    end
    x0 = n_xfer;
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    check("release_valid", 68'(out_valid), 68'(0));
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    check("one_xfer", 68'(n_xfer - x0), 68'(1));

    // addi x1,x0,-1 and auipc x1,0x12345
    drive(1, 32'hFFF00093, 0, 10, 0, 1, 0, 0);
    check("addi_b", 68'(alu_b), 68'(32'hFFFFFFFF));
    drive(1, 32'h12345097, 32'h100, 0, 0, 1, 0, 0);
    check("auipc_entry", {illegal, alu_op, alu_a, alu_b}, {1'b0, 3'd0, 32'h100, 32'h12345000});

    // flush while an entry is held and input is offered
    drive(1, 32'h002081B3, 0, 1, 2, 0, 0, 0);
    in_valid = 1; instr = 32'hFFF00093; flush = 1; out_ready = 0;
    #1 check("flush_ready", 68'(in_ready), 68'(0));
    @(posedge clk); #1;
    check("flush_valid", 68'(out_valid), 68'(0));
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    check("flush_no_capture", 68'(out_valid), 68'(0));

    // saturating illegal counter
    for (int i = 0; i < 300; i++) begin
      drive(1, 32'h00000000, 0, 0, 0, 1, 0, 0);
      check("illegal_flag", 68'(illegal), 68'(1));
    end
    check("ill_saturate", 68'(illegal_count), 68'(255));
    drive(0, 0, 0, 0, 0, 1, 1, 0);
    check("flush_keeps_cnt", 68'(illegal_count), 68'(255));

    // back-to-back R-type stream, then reset mid-stream
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h0020C1B3 | (32'(i) << 7), 0, 32'(i), 32'(i + 1), 1, 0, 0);
      check("stream_valid", 68'(out_valid), 68'(1));
    end
    drive(1, 32'h002081B3, 0, 3, 3, 1, 0, 1);
    check("midrst_outs", {out_valid, illegal, alu_op, alu_a, alu_b, illegal_count},
          68'(0));

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 3) != 0, rand_instr(), $urandom(), $urandom(), $urandom(),
            $urandom_range(0, 2) != 0, $urandom_range(0, 11) == 0,
            $urandom_range(0, 99) == 0);
    end
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The block SHALL use a single clock; reset SHALL be synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  instr/pc/rs1_data/rs2_data valid this cycle.
REQ-005 in_ready  output  1  block accepts the input this cycle.
REQ-006 instr  input  32  RV32 instruction word.
REQ-007 pc  input  32  instruction address.
REQ-008 rs1_data, rs2_data  input  32 each  register-file operands.
REQ-009 flush  input  1  discard the held entry; block the input this cycle.
REQ-010 out_valid  output  1  alu_op/alu_a/alu_b/illegal hold a valid entry.
REQ-011 out_ready  input  1  downstream ALU stage consumes the entry.
REQ-012 alu_op  output  3  ALU op code: 000 add, 001 sub, 010 and, 011 or, 100 xor.
REQ-013 alu_a, alu_b  output  32 each  ALU operands.
REQ-014 illegal  output  1  the held entry is an unsupported encoding.
REQ-015 illegal_count  output  8  saturating count of accepted illegal entries.

Function
REQ-016 Decode: opcode = instr[6:0], funct3 = instr[14:12], funct7 = instr[31:25].
REQ-017 R-type 0110011 SHALL set a = rs1_data, b = rs2_data.
REQ-018 R-type ops: f3 000/f7 0000000 -> 000; f3 000/f7 0100000 -> 001; f3 111/f7 0 -> 010; f3 110/f7 0 -> 011; f3 100/f7 0 -> 100.
REQ-019 I-type 0010011 SHALL set a = rs1_data, b = sign-extended instr[31:20].
REQ-020 I-type ops: f3 000 -> 000, 111 -> 010, 110 -> 011, 100 -> 100.
REQ-021 Load 0000011 (any funct3) SHALL produce op 000, a = rs1_data, b = sext(instr[31:20]).
REQ-022 Store 0100011 SHALL produce op 000, a = rs1_data, b = sext({instr[31:25], instr[11:7]}).
REQ-023 Branch 1100011 with f3 000 or 001 SHALL produce op 001, a = rs1_data, b = rs2_data.
REQ-024 LUI 0110111 SHALL produce op 000, a = 0, b = {instr[31:12], 12'b0}.
REQ-025 AUIPC 0010111 SHALL produce op 000, a = pc, b = {instr[31:12], 12'b0}.
REQ-026 Any other encoding SHALL produce illegal = 1, op 000, a = 0, b = 0.
REQ-027 Output stage SHALL be a single registered entry; latency SHALL be exactly 1 cycle from acceptance to out_valid.
REQ-028 in_ready SHALL equal !flush && (!out_valid || out_ready), combinationally.
REQ-029 Acceptance SHALL occur when in_valid && in_ready; the entry SHALL load at that clock edge.
REQ-030 If out_valid && out_ready && no acceptance, out_valid SHALL clear at the next edge.
REQ-031 While out_valid && !out_ready, alu_op, alu_a, alu_b and illegal SHALL hold stable.
REQ-032 Simultaneous consume and accept SHALL load the new entry with out_valid remaining 1 (full throughput).
REQ-033 flush SHALL clear out_valid at the next edge, drop the held entry and override out_ready and in_valid.
REQ-034 illegal_count SHALL increment on each accepted illegal entry, saturate at 255, and not be cleared by flush.
REQ-035 Payload outputs SHALL retain their last values when out_valid = 0.

Reset
REQ-036 While rst = 1 at an edge: out_valid = 0, alu_op = 000, alu_a = 0, alu_b = 0, illegal = 0, illegal_count = 0.
REQ-037 Reset SHALL take priority over flush and acceptance; an entry held mid-transfer SHALL be discarded.
REQ-038 in_ready SHALL be 1 in the first cycle after reset deasserts, unless flush = 1.

Verification
REQ-039 Send add x3,x1,x2 (0x002081B3), rs1 = 5, rs2 = 7, out_ready = 1 -> next cycle out_valid = 1, op 000, a = 5, b = 7.
REQ-040 Send sub (0x402081B3) with out_ready = 0 for 3 cycles -> outputs stable, op 001, in_ready = 0; on release, one transfer only.
REQ-041 Send addi x1,x0,-1 (0xFFF00093) -> b = 0xFFFFFFFF; send auipc x1,0x12345 with pc = 0x100 -> op 000, a = 0x100, b = 0x12345000.
REQ-042 Send 300 back-to-back illegal words (0x00000000) -> illegal = 1 for each entry, illegal_count saturates at 255.
REQ-043 Assert flush while an entry is held and in_valid = 1 -> in_ready = 0, out_valid = 0 next cycle, input not captured.
REQ-044 Stream 4 R-type entries with out_ready = 1 throughout -> 4 consecutive out_valid cycles with no bubble; assert rst mid-stream -> all outputs at reset values next cycle.
